// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths and constants for the pipelined ARM core.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int                 PC_W      = 64;
    localparam int                 INSTR_W   = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

endpackage
`default_nettype wire

// File: rtl/branch_target.sv
`default_nettype none
// ============================================================================
// Module      : branch_target
// Description : Taken-branch target = pc_id + (sext(imm26 | imm19) << 2).
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target
    import cpu_pkg::*;
#(
    parameter int PC_W = cpu_pkg::PC_W
) (
    input  logic [PC_W-1:0] pc_id,
    input  logic            uncond_br,
    input  logic [25:0]     imm26,
    input  logic [18:0]     imm19,
    output logic [PC_W-1:0] target
);

    logic [PC_W-1:0] w_offset;

    // Word offset sign-extended to full PC width before scaling to bytes;
    // the add wraps modulo 2^PC_W by construction.
    always_comb begin
        if (uncond_br) begin
            w_offset = {{(PC_W-26){imm26[25]}}, imm26};
        end else begin
            w_offset = {{(PC_W-19){imm19[18]}}, imm19};
        end
        target = pc_id + {w_offset[PC_W-3:0], 2'b00};
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : PC register, instruction fetch and IF/ID pipeline register
//               with stall hold and one-bubble taken-branch redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int              PC_W     = cpu_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            br_taken,
    input  logic            uncond_br,
    input  logic [25:0]     imm26,
    input  logic [18:0]     imm19,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr_id,
    output logic [PC_W-1:0] pc_id,
    output logic            valid_id
);

    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_instr;
    logic [PC_W-1:0] r_pc_id;
    logic            r_valid;
    logic [PC_W-1:0] w_target;
    logic            w_br_act;

    branch_target #(
        .PC_W (PC_W)
    ) u_branch_target (
        .pc_id     (r_pc_id),
        .uncond_br (uncond_br),
        .imm26     (imm26),
        .imm19     (imm19),
        .target    (w_target)
    );

    // A branch flagged against a bubble is meaningless and must not redirect.
    assign w_br_act = br_taken & r_valid & ~stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_pc_id <= '0;
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_pc_id <= r_pc;
            if (w_br_act) begin
                // Word fetched this cycle is wrong-path: squash it to a NOP.
                r_pc    <= w_target;
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end else begin
                r_pc    <= r_pc + PC_W'(4);
                r_instr <= imem_rdata;
                r_valid <= 1'b1;
            end
        end
    end

    assign imem_addr = r_pc;
    assign instr_id  = r_instr;
    assign pc_id     = r_pc_id;
    assign valid_id  = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic        uncond_br = 1'b0;
    logic [25:0] imm26 = '0;
    logic [18:0] imm19 = '0;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_id;
    logic [63:0] pc_id;
    logic        valid_id;

    logic [31:0] salt = '0;

    // Reference model state
    logic [63:0] m_pc = '0;
    logic [31:0] m_instr = NOP;
    logic [63:0] m_pcid = '0;
    logic        m_valid = 1'b0;

    int checks = 0;
    int errors = 0;

    fetch_stage #(
        .PC_W     (64),
        .RESET_PC (64'h0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_taken   (br_taken),
        .uncond_br  (uncond_br),
        .imm26      (imm26),
        .imm19      (imm19),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .instr_id   (instr_id),
        .pc_id      (pc_id),
        .valid_id   (valid_id)
    );

    always #5 clk = ~clk;

    // Instruction memory: word at address A is A (xor an optional salt).
    always_comb imem_rdata = imem_addr[31:0] ^ salt;

    // Advance one clock, stepping the model by the fetch rules.
    task automatic tick();
        logic [63:0]        n_pc, n_pcid;
        logic [31:0]        n_instr;
        logic               n_valid;
        logic signed [63:0] off;
        n_pc = m_pc; n_pcid = m_pcid; n_instr = m_instr; n_valid = m_valid;
        if (reset) begin
            n_pc = 64'h0; n_instr = NOP; n_pcid = 64'h0; n_valid = 1'b0;
        end else if (!stall) begin
            if (br_taken && m_valid) begin
                if (uncond_br) off = $signed(imm26);
                else           off = $signed(imm19);
                n_pc = m_pcid + off * 4;
                n_instr = NOP; n_pcid = m_pc; n_valid = 1'b0;
            end else begin
                n_pc = m_pc + 64'd4;
                n_instr = m_pc[31:0] ^ salt;
                n_pcid = m_pc; n_valid = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_pcid = n_pcid; m_instr = n_instr; m_valid = n_valid;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; br_taken = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; br_taken = 1'b0;
        tick();
        tick();
        checks++;
        if ({imem_addr, instr_id, pc_id, valid_id} !== {64'h0, NOP, 64'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got addr=%h instr=%h pc_id=%h v=%b want 0/%h/0/0",
                     imem_addr, instr_id, pc_id, valid_id, NOP);
        end
        reset = 1'b0;
    endtask

    task automatic test_free_run();
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if ({imem_addr, instr_id, pc_id, valid_id} !==
                {64'(4 * k), 32'(4 * (k - 1)), 64'(4 * (k - 1)), 1'b1}) begin
                errors++;
                $display("FAIL free_run[%0d]: got addr=%h instr=%h pc_id=%h v=%b",
                         k, imem_addr, instr_id, pc_id, valid_id);
            end
        end
    endtask

    task automatic test_uncond_branch();
        do_reset();
        repeat (5) tick();
        br_taken = 1'b1; uncond_br = 1'b1; imm26 = 26'd3;
        tick();
        br_taken = 1'b0;
        checks++;
        if ({imem_addr, instr_id, pc_id, valid_id} !== {64'h1C, NOP, 64'h14, 1'b0}) begin
            errors++;
            $display("FAIL uncond_redirect: got addr=%h instr=%h pc_id=%h v=%b want 1c/nop/14/0",
                     imem_addr, instr_id, pc_id, valid_id);
        end
        tick();
        checks++;
        if ({imem_addr, instr_id, pc_id, valid_id} !== {64'h20, 32'h1C, 64'h1C, 1'b1}) begin
            errors++;
            $display("FAIL uncond_target: got addr=%h instr=%h pc_id=%h v=%b want 20/1c/1c/1",
                     imem_addr, instr_id, pc_id, valid_id);
        end
    endtask

    task automatic test_cond_branch();
        do_reset();
        repeat (17) tick();
        br_taken = 1'b1; uncond_br = 1'b0; imm19 = 19'h7FFFE;
        tick();
        br_taken = 1'b0;
        checks++;
        if (imem_addr !== 64'h38 || valid_id !== 1'b0) begin
            errors++;
            $display("FAIL cond_backward: got addr=%h v=%b want 38/0", imem_addr, valid_id);
        end
        do_reset();
        tick();
        br_taken = 1'b1; uncond_br = 1'b0; imm19 = 19'h7FFFF;
        tick();
        br_taken = 1'b0;
        checks++;
        if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++;
            $display("FAIL cond_wrap: got addr=%h want fffffffffffffffc", imem_addr);
        end
    endtask

    task automatic test_stall_then_branch();
        do_reset();
        repeat (8) tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                br_taken = 1'b1; uncond_br = 1'b1; imm26 = 26'd2;
            end
            tick();
            checks++;
            if ({imem_addr, instr_id, pc_id, valid_id} !== {64'h20, 32'h1C, 64'h1C, 1'b1}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got addr=%h instr=%h pc_id=%h v=%b want 20/1c/1c/1",
                         k, imem_addr, instr_id, pc_id, valid_id);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if ({imem_addr, instr_id, pc_id, valid_id} !== {64'h24, NOP, 64'h20, 1'b0}) begin
            errors++;
            $display("FAIL stall_release_redirect: got addr=%h instr=%h pc_id=%h v=%b want 24/nop/20/0",
                     imem_addr, instr_id, pc_id, valid_id);
        end
        // br_taken still high against the bubble: must be ignored
        tick();
        checks++;
        if ({imem_addr, instr_id, pc_id, valid_id} !== {64'h28, 32'h24, 64'h24, 1'b1}) begin
            errors++;
            $display("FAIL bubble_ignored: got addr=%h instr=%h pc_id=%h v=%b want 28/24/24/1",
                     imem_addr, instr_id, pc_id, valid_id);
        end
        // Branch at the target is honoured: 0x24 + 8
        tick();
        br_taken = 1'b0;
        checks++;
        if ({imem_addr, valid_id} !== {64'h2C, 1'b0}) begin
            errors++;
            $display("FAIL back_to_back: got addr=%h v=%b want 2c/0", imem_addr, valid_id);
        end
        tick();
        checks++;
        if ({imem_addr, instr_id, valid_id} !== {64'h30, 32'h2C, 1'b1}) begin
            errors++;
            $display("FAIL back_to_back_target: got addr=%h instr=%h v=%b want 30/2c/1",
                     imem_addr, instr_id, valid_id);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        repeat (4) tick();
        stall = 1'b1; br_taken = 1'b1; uncond_br = 1'b1; imm26 = 26'd100;
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({imem_addr, instr_id, pc_id, valid_id} !== {64'h0, NOP, 64'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_stall: got addr=%h instr=%h pc_id=%h v=%b",
                     imem_addr, instr_id, pc_id, valid_id);
        end
        reset = 1'b0; stall = 1'b0;
        tick();
        br_taken = 1'b0;
        checks++;
        if ({imem_addr, instr_id, valid_id} !== {64'h4, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_discards_branch: got addr=%h instr=%h v=%b want 4/0/1",
                     imem_addr, instr_id, valid_id);
        end
    endtask

    task automatic test_random();
        salt = $urandom;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            reset     = ($urandom_range(0, 99) < 2);
            stall     = ($urandom_range(0, 99) < 25);
            br_taken  = ($urandom_range(0, 99) < 35);
            uncond_br = $urandom_range(0, 1) == 1;
            imm26     = 26'($urandom);
            imm19     = 19'($urandom);
            tick();
            checks++;
            if ({imem_addr, instr_id, pc_id, valid_id} !== {m_pc, m_instr, m_pcid, m_valid}) begin
                errors++;
                $display("FAIL random[%0d]: got addr=%h instr=%h pc_id=%h v=%b want %h/%h/%h/%b",
                         k, imem_addr, instr_id, pc_id, valid_id, m_pc, m_instr, m_pcid, m_valid);
            end
        end
        reset = 1'b0; stall = 1'b0; br_taken = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_uncond_branch();
        test_cond_branch();
        test_stall_then_branch();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
